hamming_ser_rx: RTL
===================

HAMMING_SER_RX -- requirements
Module: hamming_ser_rx

Interface
REQ-001 Parameters: none; codeword width fixed at 12, data width fixed at 7.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 bit_in  input  1  serial codeword bit, sampled only when bit_valid=1.
REQ-005 bit_valid  input  1  qualifies bit_in for one clk cycle.
REQ-006 sof  input  1  start-of-frame marker; meaningful only with bit_valid=1, marks codeword bit 0.
REQ-007 q  output  7  decoded (corrected) data word.
REQ-008 q_valid  output  1  output buffer holds a decoded word.
REQ-009 q_ready  input  1  consumer accepts q when q_valid & q_ready.
REQ-010 err_detected  output  1  any error found in the word in q; valid with q_valid.
REQ-011 err_corrected  output  1  single-bit error corrected in the word in q; valid with q_valid.
REQ-012 err_fatal  output  1  uncorrectable error in the word in q; valid with q_valid.
REQ-013 frame_err  output  1  one-cycle pulse: frame aborted by early sof.
REQ-014 overflow  output  1  one-cycle pulse: decoded word dropped because the output buffer was full.
REQ-015 corr_cnt, fatal_cnt  output  8 each  saturating counts of corrected and fatal words.

Function
REQ-016 Code is SEC-DED: cw[0]=overall parity; cw[1],cw[2],cw[4],cw[8] are Hamming parity; data d[0..6] occupy cw[3],cw[5],cw[6],cw[7],cw[9],cw[10],cw[11].
REQ-017 Parity bit at position 2^k is the XOR of all positions 1..11 whose index has bit k set; cw[0] is the XOR of cw[11:1] (even overall parity).
REQ-018 Bits arrive LSB first: cw[0] with sof=1, then cw[1]..cw[11] on subsequent bit_valid cycles; idle cycles between bits are allowed.
REQ-019 FSM states: IDLE, RECV, DECODE.
REQ-020 IDLE: bit_valid & sof loads bit 0, sets bit counter to 1, moves to RECV; bit_valid without sof is ignored.
REQ-021 RECV: each bit_valid stores the bit at the counter index and increments the counter; accepting bit 11 moves to DECODE.
REQ-022 RECV with bit_valid & sof: abort the current frame, pulse frame_err, restart with this bit as cw[0].
REQ-023 DECODE lasts exactly one cycle; all bit_valid/sof inputs in that cycle are ignored; next state is IDLE.
REQ-024 Syndrome s[3:0] = XOR of indices of set bits in cw[11:1]; op = XOR of cw[11:0].
REQ-025 s=0, op=0: no error, all error flags 0.
REQ-026 op=1, s in 0..11: flip cw[s]; err_detected=1, err_corrected=1 (s=0 means parity bit only).
REQ-027 op=1 with s in 12..15, or op=0 with s!=0: err_detected=1, err_fatal=1, q = uncorrected data bits.
REQ-028 Latency: bit 11 accepted at edge N -> q_valid and flags high after edge N+2.
REQ-029 Commit at the end of DECODE succeeds if the buffer is empty or is popped (q_valid & q_ready) in the same cycle; otherwise the word is dropped, overflow pulses, and the buffer is unchanged.
REQ-030 q and flags are stable while q_valid=1 and q_ready=0; q_valid clears on pop with no new commit.
REQ-031 corr_cnt and fatal_cnt increment on committed words only and saturate at 255.

Reset
REQ-032 rst_n=0 forces IDLE, bit counter 0, q=0, q_valid=0, all flags/pulses 0, and both counters 0 regardless of clk.
REQ-033 Reset asserted mid-frame or with q_valid=1 discards the partial frame and the buffered word; after release, the first frame requires a fresh sof.

Verification
REQ-034 Clean frame 12'h93A sent LSB first with q_ready=1 -> q=7'h43, q_valid high after edge N+2, all error flags 0.
REQ-035 Frame 12'h97A (bit 6 flipped) -> q=7'h43, err_detected=1, err_corrected=1, corr_cnt=1.
REQ-036 Frame 12'h9FA (bits 6 and 7 flipped) -> err_detected=1, err_fatal=1, fatal_cnt=1; frame 12'h93B -> q=7'h43, err_corrected=1.
REQ-037 Second sof after 5 bits, then a full 12'h000 frame -> one frame_err pulse, then q=7'h00 with no error flags.
REQ-038 Two back-to-back frames with q_ready=0 -> first word held in q; second commit pulses overflow; q still shows the first word.
REQ-039 rst_n asserted after 6 bits, released, then 12'h93A -> no output from the partial frame; q=7'h43 with counters 0.

Source files
------------

// File: rtl/hamming_ser_rx.sv
// Serial SEC-DED (12,7) Hamming receiver: assembles an LSB-first codeword,
// decodes and corrects it, and holds the result in a one-entry output buffer.
module hamming_ser_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       sof,
    output logic [6:0] q,
    output logic       q_valid,
    input  logic       q_ready,
    output logic       err_detected,
    output logic       err_corrected,
    output logic       err_fatal,
    output logic       frame_err,
    output logic       overflow,
    output logic [7:0] corr_cnt,
    output logic [7:0] fatal_cnt
);

    typedef enum logic [1:0] {IDLE, RECV, DECODE} state_t;

    state_t      state, state_nxt;
    logic [11:0] cw, cw_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        abort;

    logic [3:0]  syn;
    logic        op;
    logic [11:0] cw_fix;
    logic [6:0]  dec_data;
    logic        dec_det, dec_corr, dec_fatal;

    logic        pend;
    logic [6:0]  pend_q;
    logic        pend_det, pend_corr, pend_fatal;
    logic        commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cw    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cw    <= cw_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cw_nxt    = cw;
        cnt_nxt   = cnt;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (bit_valid && sof) begin
                    cw_nxt    = {11'b0, bit_in};
                    cnt_nxt   = 4'd1;
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (bit_valid && sof) begin
                    abort   = 1'b1;
                    cw_nxt  = {11'b0, bit_in};
                    cnt_nxt = 4'd1;
                end else if (bit_valid) begin
                    cw_nxt[cnt] = bit_in;
                    if (cnt == 4'd11) begin
                        cnt_nxt   = '0;
                        state_nxt = DECODE;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            DECODE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Syndrome is the XOR of the positions of all set bits; s=0 with op=1 hits cw[0].
    always_comb begin
        syn = '0;
        for (int unsigned i = 1; i < 12; i++) begin
            if (cw[i]) syn = syn ^ i[3:0];
        end
        op        = ^cw;
        cw_fix    = cw;
        dec_det   = 1'b0;
        dec_corr  = 1'b0;
        dec_fatal = 1'b0;
        if (op && syn <= 4'd11) begin
            cw_fix[syn] = ~cw[syn];
            dec_det     = 1'b1;
            dec_corr    = 1'b1;
        end else if (op || syn != 4'd0) begin
            dec_det   = 1'b1;
            dec_fatal = 1'b1;
        end
        dec_data = {cw_fix[11], cw_fix[10], cw_fix[9], cw_fix[7],
                    cw_fix[6], cw_fix[5], cw_fix[3]};
    end

    // Decode result is registered at the end of DECODE, then committed a cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= 1'b0;
            pend_q     <= '0;
            pend_det   <= 1'b0;
            pend_corr  <= 1'b0;
            pend_fatal <= 1'b0;
        end else begin
            pend <= (state == DECODE);
            if (state == DECODE) begin
                pend_q     <= dec_data;
                pend_det   <= dec_det;
                pend_corr  <= dec_corr;
                pend_fatal <= dec_fatal;
            end
        end
    end

    assign commit = pend && (!q_valid || q_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q             <= '0;
            q_valid       <= 1'b0;
            err_detected  <= 1'b0;
            err_corrected <= 1'b0;
            err_fatal     <= 1'b0;
            frame_err     <= 1'b0;
            overflow      <= 1'b0;
            corr_cnt      <= '0;
            fatal_cnt     <= '0;
        end else begin
            frame_err <= abort;
            overflow  <= pend && q_valid && !q_ready;
            if (commit) begin
                q             <= pend_q;
                q_valid       <= 1'b1;
                err_detected  <= pend_det;
                err_corrected <= pend_corr;
                err_fatal     <= pend_fatal;
                if (pend_corr && corr_cnt != 8'hFF)   corr_cnt  <= corr_cnt + 8'd1;
                if (pend_fatal && fatal_cnt != 8'hFF) fatal_cnt <= fatal_cnt + 8'd1;
            end else if (q_valid && q_ready) begin
                q_valid <= 1'b0;
            end
        end
    end

endmodule
